// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_pkg                                                          |
// | Brief  : Shared constants, FSM encoding and parameter check for uart_rx_os |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_t;

    function automatic bit data_bits_ok(input int n);
        return (n >= DATA_BITS_MIN) && (n <= DATA_BITS_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_os_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_os_tick_gen                                                  |
// | Brief  : Oversample tick divider, one pulse every CLK_DIV clocks,          |
// |          re-phased to zero by i_restart                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_os_tick_gen #(
    parameter int CLK_DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_os                                                        |
// | Brief  : Oversampling UART receiver, 5..9 data bits, none/even/odd parity, |
// |          1/2 stop bits, valid/ready output with error flags.               |
// |          Optional: UART_RX_BREAK_DETECT_EN adds break_det output.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 54,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 break_det,
`endif
    output logic                 busy
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0]  C_OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  C_OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_BITS - 1);

    generate
        if (!data_bits_ok(DATA_BITS)) begin : g_bad_data_bits
            $error("uart_rx_os: DATA_BITS must be 5..9");
        end
    endgenerate

    logic                 r_sync1, r_sync2;
    uart_state_t          r_state, w_state_nxt;
    logic [OS_W-1:0]      r_os_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_armed, r_perr, r_ferr, r_cmp, r_stop2;
    logic [1:0]           r_par_mode;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_parity_err, r_frame_err, r_overrun_err;
    logic                 w_rx_s, w_tick, w_os_done, w_sample, w_start, w_restart;
    logic                 w_ferr_now, w_complete;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 r_all_zero, r_break, w_break;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx_s = r_sync2;

    assign w_start   = r_armed && !w_rx_s;
    assign w_restart = (r_state == ST_IDLE) && w_start;

    uart_os_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        w_break     = 1'b0;
`endif
        w_os_done   = (r_state == ST_START) ? (r_os_cnt == C_OS_HALF) : (r_os_cnt == C_OS_LAST);
        w_sample    = w_tick && w_os_done;
        w_ferr_now  = r_ferr | ~w_rx_s;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_nxt = ST_START;
            ST_START:  if (w_sample) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (w_sample && (r_bit_cnt == C_BIT_LAST)) begin
                    w_state_nxt = ((r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD))
                                  ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: if (w_sample) w_state_nxt = ST_STOP1;
            ST_STOP1: begin
                if (w_sample) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (r_all_zero && !w_rx_s) begin
                        w_break     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else
`endif
                    if (r_stop2) begin
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_complete  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (w_sample) begin
                    w_state_nxt = ST_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath; flags of the finished frame stay put until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b1;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_cmp      <= 1'b0;
            r_stop2    <= 1'b0;
            r_par_mode <= PAR_NONE;
`ifdef UART_RX_BREAK_DETECT_EN
            r_all_zero <= 1'b0;
            r_break    <= 1'b0;
`endif
        end else begin
            r_cmp <= w_complete;
`ifdef UART_RX_BREAK_DETECT_EN
            r_break <= w_break;
`endif
            if (r_state == ST_IDLE) begin
                if (w_rx_s) r_armed <= 1'b1;
                if (w_start) begin
                    r_os_cnt   <= '0;
                    r_bit_cnt  <= '0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                    r_par_mode <= parity_mode;
                    r_stop2    <= stop2;
`ifdef UART_RX_BREAK_DETECT_EN
                    r_all_zero <= 1'b1;
`endif
                end
            end else if (w_tick) begin
                r_os_cnt <= w_os_done ? '0 : r_os_cnt + 1'b1;
            end
            if (w_sample) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        r_all_zero <= r_all_zero & ~w_rx_s;
`endif
                    end
                    ST_PARITY: begin
                        r_perr <= (^r_shift) ^ w_rx_s ^ (r_par_mode == PAR_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
                        r_all_zero <= r_all_zero & ~w_rx_s;
`endif
                    end
                    ST_STOP1, ST_STOP2: r_ferr <= w_ferr_now;
                    default: ;
                endcase
            end
            if (w_complete) r_armed <= ~w_ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
            if (w_break) r_armed <= 1'b0;
`endif
        end
    end

    // Output holding register: a frame arriving while one is still held is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (r_cmp) begin
            if (!r_rx_valid || rx_ready) begin
                r_rx_data     <= r_shift;
                r_parity_err  <= r_perr;
                r_frame_err   <= r_ferr;
                r_overrun_err <= 1'b0;
                r_rx_valid    <= 1'b1;
            end else begin
                r_overrun_err <= 1'b1;
            end
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != ST_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det   = r_break;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_rx_os                                                     |
// | Brief  : Directed self-checking bench for uart_rx_os (CLK_DIV=4, OS=16)    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_uart_rx_os;

    localparam int CLK_DIV    = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int BIT_CLK    = CLK_DIV * OVERSAMPLE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [1:0] parity_mode;
    logic       stop2;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, parity_err, frame_err, overrun_err, busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       break_det;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       oe;
    } frame_t;

    frame_t r_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     n_vld = 0;
    int     n_brk = 0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det   (break_det),
`endif
        .busy        (busy)
    );

    always @(negedge clk) begin
        frame_t f;
        if (rx_valid) n_vld++;
        if (rx_valid && rx_ready) begin
            f = '{d: rx_data, pe: parity_err, fe: frame_err, oe: overrun_err};
            r_q.push_back(f);
        end
`ifdef UART_RX_BREAK_DETECT_EN
        if (break_det) n_brk++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic flip,
                              input logic s2, input logic s2val);
        logic p;
        parity_mode = pm;
        stop2       = s2;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pm == 2'd1 || pm == 2'd2) begin
            p = (^d) ^ (pm == 2'd2);
            send_bit(p ^ flip);
        end
        send_bit(1'b1);
        if (s2) send_bit(s2val);
        send_bit(1'b1);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                                input logic fe, input logic oe);
        frame_t f;
        chk({tag, "_count"}, r_q.size(), 1);
        if (r_q.size() > 0) begin
            f = r_q.pop_front();
            chk({tag, "_data"}, f.d, d);
            chk({tag, "_perr"}, f.pe, pe);
            chk({tag, "_ferr"}, f.fe, fe);
            chk({tag, "_ovr"},  f.oe, oe);
        end
        r_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        rx          = 1'b1;
        rx_ready    = 1'b1;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_data",  rx_data, 0);
        chk("rst_flags", {parity_err, frame_err, overrun_err}, 0);
        rst_n = 1'b1;
        repeat (BIT_CLK) @(negedge clk);

        n_vld = 0;
        send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("a5_vld_cycles", n_vld, 1);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b1);
        expect_frame("mode3", 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 2'd1, 1'b0, 1'b0, 1'b1);
        expect_frame("even_ok", 8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 2'd1, 1'b1, 1'b0, 1'b1);
        expect_frame("even_bad", 8'h3C, 1'b1, 1'b0, 1'b0);

        send_frame(8'h0F, 2'd2, 1'b0, 1'b1, 1'b0);
        expect_frame("odd_stop2_bad", 8'h0F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 2'd2, 1'b0, 1'b1, 1'b1);
        expect_frame("odd_stop2_ok", 8'h55, 1'b0, 1'b0, 1'b0);

        n_vld       = 0;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        rx          = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_no_valid", n_vld, 0);

        @(posedge clk); #1 rx_ready = 1'b0;
        send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data",  rx_data, 8'h11);
        chk("ovr_flag",  overrun_err, 1);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovr_accept_drop", rx_valid, 0);
        expect_frame("ovr_held", 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 2'd0, 1'b0, 1'b0, 1'b1);
        expect_frame("after_ovr", 8'h33, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_busy",  busy, 0);
        chk("midrst_data",  rx_data, 0);
        rst_n = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        r_q.delete();
        send_frame(8'h7E, 2'd0, 1'b0, 1'b0, 1'b1);
        expect_frame("after_rst", 8'h7E, 1'b0, 1'b0, 1'b0);

        n_vld       = 0;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        send_bit(1'b0);
        repeat (11) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("break_pulses", n_brk, 1);
        chk("break_no_valid", n_vld, 0);
`else
        expect_frame("zero_frame", 8'h00, 1'b0, 1'b1, 1'b0);
`endif
        send_frame(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1);
        expect_frame("after_break", 8'hC3, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
